// File: rtl/timer_load_ctrl_if.sv
// timer_load_ctrl_if -- keypad/control strobes in, BCD load bus and status out.
//
// Handshake semantics: key_valid, start and stop are single-cycle strobes,
// sampled on the rising clock edge and never held off (there is no ready).
// zero_in is a level from the downstream countdown chain. On the output side,
// loadn low for one cycle means "capture mins/sec_tens/sec_ones now". en is a
// level count enable. err is a single-cycle pulse. busy and done are levels.
//
// master : keypad / controller side (drives strobes and zero_in)
// slave  : timer_load_ctrl (drives load data and status)
interface timer_load_ctrl_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       zero_in;
  logic [3:0] mins;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       loadn;
  logic       en;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output key_valid, key_digit, start, stop, zero_in,
    input  mins, sec_tens, sec_ones, loadn, en, busy, done, err
  );

  modport slave (
    input  key_valid, key_digit, start, stop, zero_in,
    output mins, sec_tens, sec_ones, loadn, en, busy, done, err
  );
endinterface

// File: rtl/timer_load_ctrl.sv
// timer_load_ctrl -- keypad entry and load/run/pause control for an m:ss
// countdown chain.
//
// Ports:
//   clock      sole clock, rising edge
//   clrn       asynchronous active-low reset
//   bus        timer_load_ctrl_if.slave
//                in : key_valid, key_digit, start, stop, zero_in
//                out: mins, sec_tens, sec_ones, loadn, en, busy, done, err
//   state_dbg  current FSM state (IDLE=0 LOAD=1 RUN=2 PAUSE=3 DONE=4)
//
// Digits are entered right to left: every accepted key shifts the display
// left by one digit. Every output comes straight from a flop.
module timer_load_ctrl #(
  parameter int MAX_TENS  = 5,
  parameter int DIGIT_MAX = 9
) (
  input  logic              clock,
  input  logic              clrn,
  timer_load_ctrl_if.slave  bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] TENS_LIM  = 4'(MAX_TENS);
  localparam logic [3:0] DIGIT_LIM = 4'(DIGIT_MAX);

  state_t     state;
  logic [3:0] mins_q;
  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic       loadn_q;
  logic       en_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;

  logic key_ok;
  logic digits_zero;
  logic tens_bad;

  assign key_ok      = bus.key_valid && (bus.key_digit <= DIGIT_LIM);
  assign digits_zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign tens_bad    = (tens_q > TENS_LIM);

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      mins_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      loadn_q <= 1'b1;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          // stop outranks start and keys; it discards a partial entry.
          if (bus.stop) begin
            mins_q <= 4'd0;
            tens_q <= 4'd0;
            ones_q <= 4'd0;
          end else if (bus.start) begin
            // Judged on pre-shift digits: a key in the same cycle is dropped.
            if (tens_bad) begin
              err_q <= 1'b1;
            end else if (!digits_zero) begin
              state   <= LOAD;
              loadn_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end else if (key_ok) begin
            mins_q <= tens_q;
            tens_q <= ones_q;
            ones_q <= bus.key_digit;
          end
        end
        LOAD: begin
          state   <= RUN;
          loadn_q <= 1'b1;
          en_q    <= 1'b1;
        end
        RUN: begin
          // Reaching zero wins over a simultaneous stop.
          if (bus.zero_in) begin
            state  <= DONE;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (bus.stop) begin
            state <= PAUSE;
            en_q  <= 1'b0;
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            mins_q <= 4'd0;
            tens_q <= 4'd0;
            ones_q <= 4'd0;
          end else if (bus.start) begin
            // Resume without reloading: the counters keep their count.
            state <= RUN;
            en_q  <= 1'b1;
          end
        end
        DONE: begin
          // Any key acknowledges completion; that key is consumed here.
          if (bus.start || bus.stop || bus.key_valid) begin
            state  <= IDLE;
            done_q <= 1'b0;
            mins_q <= 4'd0;
            tens_q <= 4'd0;
            ones_q <= 4'd0;
          end
        end
        default: begin
          state   <= IDLE;
          loadn_q <= 1'b1;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mins     = mins_q;
  assign bus.sec_tens = tens_q;
  assign bus.sec_ones = ones_q;
  assign bus.loadn    = loadn_q;
  assign bus.en       = en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_timer_load_ctrl.sv
// tb_timer_load_ctrl -- directed bench for timer_load_ctrl. Load, err and
// done events are matched against an expected queue by a monitor; levels
// and digits are checked inline after each step.
module tb_timer_load_ctrl;
  localparam int W = 14;
  localparam logic [1:0] K_LOAD = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       clrn;
  logic [2:0] state_dbg;
  always #5 clock = ~clock;

  timer_load_ctrl_if bus();

  timer_load_ctrl #(.MAX_TENS(5), .DIGIT_MAX(9)) dut (
    .clock    (clock),
    .clrn     (clrn),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // ---------------- downstream countdown model ----------------
  logic zero_drv = 1'b0;
  logic loop_on  = 1'b0;
  int   cnt      = 0;
  int   dec_cnt  = 0;

  assign bus.zero_in = loop_on ? (cnt == 0) : zero_drv;

  always @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      cnt <= 0;
    end else if (!bus.loadn) begin
      cnt     <= int'(bus.mins) * 60 + int'(bus.sec_tens) * 10 + int'(bus.sec_ones);
      dec_cnt <= 0;
    end else if (bus.en && cnt != 0) begin
      cnt     <= cnt - 1;
      dec_cnt <= dec_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic exp_push(input logic [1:0] k, input logic [3:0] m, input logic [3:0] t,
                          input logic [3:0] o);
    exp_q.push_back({k, m, t, o});
  endtask

  task automatic match(input logic [1:0] k);
    logic [W-1:0] got;
    got = {k, bus.mins, bus.sec_tens, bus.sec_ones};
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL unexpected_event: got 0x%0h required none", got);
    end else begin
      chk("scoreboard_event", 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  // Monitor: one look per cycle, on the falling edge.
  initial begin : monitor
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!clrn) begin
        done_prev = 1'b0;
      end else begin
        if (!bus.loadn) match(K_LOAD);
        if (bus.err) match(K_ERR);
        if (bus.done && !done_prev) match(K_DONE);
        done_prev = bus.done;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic chk_digits(input string name, input logic [3:0] m, input logic [3:0] t,
                            input logic [3:0] o);
    chk(name, 32'({bus.mins, bus.sec_tens, bus.sec_ones}), 32'({m, t, o}));
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int budget;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    clrn = 1'b1;
    #2 clrn = 1'b0;
    #1;
    chk("reset_state", 32'(state_dbg), 32'(S_IDLE));
    chk_digits("reset_digits", 4'd0, 4'd0, 4'd0);
    chk("reset_ctrl", 32'({bus.loadn, bus.en, bus.busy, bus.done, bus.err}), 32'(5'b10000));
    @(negedge clock);
    #1 clrn = 1'b1;
    tick();

    // start with 0:00 is ignored
    do_start();
    chk("zero_start_state", 32'(state_dbg), 32'(S_IDLE));
    chk("zero_start_err", 32'(bus.err), 32'd0);

    // keys 1,3,0 then start
    key(4'd1); key(4'd3); key(4'd0);
    chk_digits("shift_130", 4'd1, 4'd3, 4'd0);
    exp_push(K_LOAD, 4'd1, 4'd3, 4'd0);
    do_start();
    chk("load_state", 32'(state_dbg), 32'(S_LOAD));
    chk("load_strobe", 32'({bus.loadn, bus.en, bus.busy}), 32'(3'b001));
    tick();
    chk("run_after_load", 32'(state_dbg), 32'(S_RUN));
    chk("run_strobe", 32'({bus.loadn, bus.en}), 32'(2'b11));

    // zero_in in RUN -> DONE, then stop returns to IDLE
    exp_push(K_DONE, 4'd1, 4'd3, 4'd0);
    zero_drv = 1'b1;
    tick();
    zero_drv = 1'b0;
    chk("done_state", 32'(state_dbg), 32'(S_DONE));
    chk("done_outputs", 32'({bus.en, bus.done, bus.busy}), 32'(3'b010));
    tick(2);
    chk("done_held", 32'(bus.done), 32'd1);
    do_stop();
    chk("done_stop_state", 32'(state_dbg), 32'(S_IDLE));
    chk_digits("done_stop_digits", 4'd0, 4'd0, 4'd0);
    chk("done_stop_done", 32'(bus.done), 32'd0);

    // keys 0,7,5 -> rejected start; key 12 ignored
    key(4'd0); key(4'd7); key(4'd5);
    key(4'd12);
    chk_digits("key12_ignored", 4'd0, 4'd7, 4'd5);
    exp_push(K_ERR, 4'd0, 4'd7, 4'd5);
    do_start();
    chk("err_pulse", 32'(bus.err), 32'd1);
    chk("err_state", 32'(state_dbg), 32'(S_IDLE));
    chk_digits("err_digits", 4'd0, 4'd7, 4'd5);
    tick();
    chk("err_one_cycle", 32'(bus.err), 32'd0);

    // pause / resume without reload
    key(4'd0); key(4'd3); key(4'd0);
    exp_push(K_LOAD, 4'd0, 4'd3, 4'd0);
    do_start();
    tick();
    do_stop();
    chk("pause_state", 32'(state_dbg), 32'(S_PAUSE));
    key(4'd9);
    chk_digits("pause_key_ignored", 4'd0, 4'd3, 4'd0);
    for (int i = 0; i < 5; i++) begin
      chk("pause_en_low", 32'(bus.en), 32'd0);
      tick();
    end
    do_start();
    chk("resume_state", 32'(state_dbg), 32'(S_RUN));
    chk("resume_strobe", 32'({bus.loadn, bus.en}), 32'(2'b11));
    do_stop();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("pause_startstop_state", 32'(state_dbg), 32'(S_IDLE));
    chk_digits("pause_startstop_digits", 4'd0, 4'd0, 4'd0);
    chk("pause_startstop_busy", 32'(bus.busy), 32'd0);

    // start + key together uses pre-shift digits; zero+stop in first RUN cycle
    key(4'd0); key(4'd2); key(4'd5);
    exp_push(K_LOAD, 4'd0, 4'd2, 4'd5);
    bus.start     = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd7;
    tick();
    bus.start     = 1'b0;
    bus.key_valid = 1'b0;
    chk("startkey_state", 32'(state_dbg), 32'(S_LOAD));
    chk_digits("startkey_digits", 4'd0, 4'd2, 4'd5);
    tick();
    exp_push(K_DONE, 4'd0, 4'd2, 4'd5);
    zero_drv = 1'b1;
    bus.stop = 1'b1;
    tick();
    zero_drv = 1'b0;
    bus.stop = 1'b0;
    chk("zero_stop_state", 32'(state_dbg), 32'(S_DONE));
    key(4'd4);
    chk("done_key_state", 32'(state_dbg), 32'(S_IDLE));
    chk_digits("done_key_not_shifted", 4'd0, 4'd0, 4'd0);

    // asynchronous reset mid-RUN
    key(4'd1); key(4'd0); key(4'd0);
    exp_push(K_LOAD, 4'd1, 4'd0, 4'd0);
    do_start();
    tick(2);
    #2 clrn = 1'b0;
    #1;
    chk("async_rst_run_state", 32'(state_dbg), 32'(S_IDLE));
    chk("async_rst_run_ctrl", 32'({bus.loadn, bus.en, bus.busy, bus.done, bus.err}),
        32'(5'b10000));
    chk_digits("async_rst_run_digits", 4'd0, 4'd0, 4'd0);
    @(negedge clock);
    #1 clrn = 1'b1;
    tick(2);
    chk("post_rst_idle", 32'({state_dbg, bus.loadn, bus.en}), 32'({S_IDLE, 2'b10}));

    // asynchronous reset mid-LOAD (before the monitor samples it)
    key(4'd2); key(4'd0); key(4'd0);
    do_start();
    #1 clrn = 1'b0;
    #1;
    chk("async_rst_load", 32'({state_dbg, bus.loadn, bus.en}), 32'({S_IDLE, 2'b10}));
    @(negedge clock);
    #1 clrn = 1'b1;
    tick(3);
    chk("post_rst_load_quiet", 32'({state_dbg, bus.loadn, bus.en}), 32'({S_IDLE, 2'b10}));

    // closed loop with the countdown model: 0:04
    loop_on = 1'b1;
    key(4'd0); key(4'd0); key(4'd4);
    exp_push(K_LOAD, 4'd0, 4'd0, 4'd4);
    exp_push(K_DONE, 4'd0, 4'd0, 4'd4);
    do_start();
    budget = 0;
    while (!bus.done && budget < 50) begin
      tick();
      budget++;
    end
    chk("loop_done_reached", 32'(bus.done), 32'd1);
    chk("loop_decrements", 32'(dec_cnt), 32'd4);
    chk("loop_count_zero", 32'(cnt), 32'd0);
    do_stop();
    loop_on = 1'b0;
    tick(3);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
